// File: rtl/led_code_sched_if.sv
// Request/grant/status bundle between the blink-code sources and the shared LED scheduler.
interface led_code_sched_if;
    logic [3:0]  REQ;
    logic [15:0] CODE;
    logic        LED;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic        BUSY;

    modport master (output REQ, CODE, input LED, GNT, DONE, BUSY);
    modport slave  (input REQ, CODE, output LED, GNT, DONE, BUSY);
endinterface

// File: rtl/led_code_sched.sv
// Shares one status LED among four sources: each granted source blinks its
// latched code count, followed by a dark gap, with round-robin arbitration.
module led_code_sched #(
    parameter int unsigned TICKCNT   = 5000000,
    parameter int unsigned ON_TICKS  = 2,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned GAP_TICKS = 8
) (
    input  logic            CLK,
    input  logic            RESET,
    led_code_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    localparam logic [31:0] TICK_LAST = 32'(TICKCNT - 1);
    localparam logic [7:0]  ON_LAST   = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST  = 8'(OFF_TICKS - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_TICKS - 1);

    state_t      state_reg;
    logic [31:0] presc_reg;
    logic [7:0]  phase_reg;
    logic [3:0]  remain_reg;
    logic [1:0]  last_reg;
    logic        led_reg;
    logic [3:0]  gnt_reg;
    logic [3:0]  done_reg;
    logic        busy_reg;

    logic [3:0]  code_arr [4];
    logic        tick;
    logic [7:0]  phase_last;
    logic        phase_end;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [3:0]  pick_code;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_code
            assign code_arr[gi] = bus.CODE[4*gi +: 4];
        end
    endgenerate

    assign tick = (presc_reg == TICK_LAST);

    always_comb begin
        phase_last = 8'd0;
        case (state_reg)
            ON:      phase_last = ON_LAST;
            OFF:     phase_last = OFF_LAST;
            GAP:     phase_last = GAP_LAST;
            default: phase_last = 8'd0;
        endcase
    end

    assign phase_end = tick && (phase_reg == phase_last);

    // Scan from farthest offset to nearest so the source right after last_reg wins;
    // offset 0 (last_reg itself) has the lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (bus.REQ[last_reg + 2'(k)]) begin
                pick_valid = 1'b1;
                pick_idx   = last_reg + 2'(k);
            end
        end
    end

    assign pick_code = code_arr[pick_idx];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_reg  <= IDLE;
            presc_reg  <= '0;
            phase_reg  <= '0;
            remain_reg <= '0;
            last_reg   <= 2'd3;
            led_reg    <= 1'b0;
            gnt_reg    <= '0;
            done_reg   <= '0;
            busy_reg   <= 1'b0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    presc_reg <= '0;
                    phase_reg <= '0;
                    if (pick_valid) begin
                        state_reg  <= ON;
                        led_reg    <= 1'b1;
                        busy_reg   <= 1'b1;
                        gnt_reg    <= 4'b0001 << pick_idx;
                        last_reg   <= pick_idx;
                        remain_reg <= (pick_code == 4'd0) ? 4'd1 : pick_code;
                    end
                end
                default: begin
                    presc_reg <= tick ? '0 : presc_reg + 32'd1;
                    if (tick) begin
                        phase_reg <= phase_end ? 8'd0 : phase_reg + 8'd1;
                    end
                    if (phase_end) begin
                        case (state_reg)
                            ON: begin
                                led_reg   <= 1'b0;
                                state_reg <= (remain_reg > 4'd1) ? OFF : GAP;
                            end
                            OFF: begin
                                led_reg    <= 1'b1;
                                state_reg  <= ON;
                                remain_reg <= remain_reg - 4'd1;
                            end
                            GAP: begin
                                state_reg  <= IDLE;
                                done_reg   <= gnt_reg;
                                gnt_reg    <= '0;
                                busy_reg   <= 1'b0;
                                remain_reg <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.LED  = led_reg;
    assign bus.GNT  = gnt_reg;
    assign bus.DONE = done_reg;
    assign bus.BUSY = busy_reg;
endmodule

// File: tb/tb_led_code_sched.sv
// Directed scenarios for the shared-LED blink scheduler with a 4-cycle tick.
module tb_led_code_sched;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    led_code_sched_if bus ();

    led_code_sched #(
        .TICKCNT  (4),
        .ON_TICKS (2),
        .OFF_TICKS(2),
        .GAP_TICKS(8)
    ) dut (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        bus.REQ  = 4'b1111;
        bus.CODE = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.LED, bus.GNT, bus.DONE, bus.BUSY} !== 10'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: led=%b gnt=%b done=%b busy=%b, required all 0",
                         i, bus.LED, bus.GNT, bus.DONE, bus.BUSY);
            end
        end
        bus.REQ = 4'b0000;
        rst_n   = 1'b1;
        step();
        checks++;
        if ({bus.LED, bus.GNT, bus.DONE, bus.BUSY} !== 10'd0) begin
            errors++;
            $display("FAIL reset_idle: led=%b gnt=%b done=%b busy=%b, required all 0",
                     bus.LED, bus.GNT, bus.DONE, bus.BUSY);
        end
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int count;
        bus.REQ  = 4'b1111;
        bus.CODE = 16'h1111;
        step();
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (bus.GNT !== exp_gnt[g] || bus.LED !== 1'b1 || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d: gnt=%b led=%b busy=%b, required gnt=%b led=1 busy=1",
                         g, bus.GNT, bus.LED, bus.BUSY, exp_gnt[g]);
            end
            count = 0;
            while (bus.GNT !== 4'b0000 && count < 200) begin
                count++;
                step();
            end
            checks++;
            if (count !== 40 || bus.DONE !== exp_gnt[g] || bus.LED !== 1'b0 || bus.BUSY !== 1'b0) begin
                errors++;
                $display("FAIL rr_seq%0d: len=%0d done=%b led=%b busy=%b, required len=40 done=%b led=0 busy=0",
                         g, count, bus.DONE, bus.LED, bus.BUSY, exp_gnt[g]);
            end
            if (g == 4) bus.REQ = 4'b0000;
            step();
        end
        checks++;
        if (bus.GNT !== 4'b0000 || bus.DONE !== 4'b0000) begin
            errors++;
            $display("FAIL rr_release: gnt=%b done=%b, required 0000 0000", bus.GNT, bus.DONE);
        end
        $display("test_round_robin done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_single();
        int  seg_len [6] = '{8, 8, 8, 8, 8, 32};
        logic seg_led [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int  cyc;
        bus.REQ  = 4'b0001;
        bus.CODE = 16'h0003;
        step();
        checks++;
        if (bus.GNT !== 4'b0001 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%b busy=%b, required 0001 1", bus.GNT, bus.BUSY);
        end
        cyc = 0;
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < seg_len[s]; i++) begin
                checks++;
                if (bus.LED !== seg_led[s] || bus.DONE !== 4'b0000 || bus.GNT !== 4'b0001) begin
                    errors++;
                    $display("FAIL single_led cyc%0d: led=%b done=%b gnt=%b, required led=%b done=0000 gnt=0001",
                             cyc, bus.LED, bus.DONE, bus.GNT, seg_led[s]);
                end
                cyc++;
                step();
            end
        end
        checks++;
        if (bus.DONE !== 4'b0001 || bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.LED !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%b gnt=%b busy=%b led=%b, required 0001 0000 0 0",
                     bus.DONE, bus.GNT, bus.BUSY, bus.LED);
        end
        bus.REQ = 4'b0000;
        step();
        checks++;
        if (bus.DONE !== 4'b0000 || bus.GNT !== 4'b0000) begin
            errors++;
            $display("FAIL single_pulse: done=%b gnt=%b, required 0000 0000", bus.DONE, bus.GNT);
        end
        $display("test_single done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_code_zero_latch();
        int count;
        int rises;
        logic prev_led;
        bus.REQ  = 4'b0010;
        bus.CODE = 16'h0000;
        step();
        checks++;
        if (bus.GNT !== 4'b0010 || bus.LED !== 1'b1) begin
            errors++;
            $display("FAIL zero_grant: gnt=%b led=%b, required 0010 1", bus.GNT, bus.LED);
        end
        count    = 0;
        rises    = 1;
        prev_led = 1'b1;
        while (bus.GNT !== 4'b0000 && count < 200) begin
            if (count == 3) bus.CODE = 16'h00F0;
            if (bus.LED === 1'b1 && prev_led === 1'b0) rises++;
            prev_led = bus.LED;
            count++;
            step();
        end
        checks++;
        if (count !== 40 || rises !== 1 || bus.DONE !== 4'b0010) begin
            errors++;
            $display("FAIL zero_latch: len=%0d blinks=%0d done=%b, required len=40 blinks=1 done=0010",
                     count, rises, bus.DONE);
        end
        bus.REQ = 4'b0000;
        step();
        $display("test_code_zero_latch done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_reset_mid();
        int count;
        bus.REQ  = 4'b0100;
        bus.CODE = 16'h0300;
        step();
        checks++;
        if (bus.GNT !== 4'b0100) begin
            errors++;
            $display("FAIL rmid_grant: gnt=%b, required 0100", bus.GNT);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (bus.LED !== 1'b1 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL rmid_on2: led=%b busy=%b, required 1 1", bus.LED, bus.BUSY);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({bus.LED, bus.GNT, bus.DONE, bus.BUSY} !== 10'd0) begin
                errors++;
                $display("FAIL rmid_abort cyc%0d: led=%b gnt=%b done=%b busy=%b, required all 0",
                         i, bus.LED, bus.GNT, bus.DONE, bus.BUSY);
            end
        end
        bus.REQ  = 4'b1100;
        bus.CODE = 16'h1100;
        rst_n    = 1'b1;
        step();
        checks++;
        if (bus.GNT !== 4'b0100 || bus.LED !== 1'b1) begin
            errors++;
            $display("FAIL rmid_first_grant: gnt=%b led=%b, required 0100 1", bus.GNT, bus.LED);
        end
        bus.REQ = 4'b0000;
        count = 0;
        while (bus.GNT !== 4'b0000 && count < 200) begin
            count++;
            step();
        end
        checks++;
        if (count !== 40 || bus.DONE !== 4'b0100) begin
            errors++;
            $display("FAIL rmid_seq: len=%0d done=%b, required len=40 done=0100", count, bus.DONE);
        end
        step();
        $display("test_reset_mid done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_early_drop();
        int count;
        int on_cycles;
        bus.REQ  = 4'b0100;
        bus.CODE = 16'h0200;
        step();
        checks++;
        if (bus.GNT !== 4'b0100) begin
            errors++;
            $display("FAIL drop_grant: gnt=%b, required 0100", bus.GNT);
        end
        count     = 0;
        on_cycles = 0;
        while (bus.GNT !== 4'b0000 && count < 200) begin
            if (count == 1) bus.REQ = 4'b0000;
            if (bus.LED === 1'b1) on_cycles++;
            count++;
            step();
        end
        checks++;
        if (count !== 56 || on_cycles !== 16 || bus.DONE !== 4'b0100) begin
            errors++;
            $display("FAIL drop_seq: len=%0d on=%0d done=%b, required len=56 on=16 done=0100",
                     count, on_cycles, bus.DONE);
        end
        step();
        checks++;
        if (bus.DONE !== 4'b0000 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL drop_after: done=%b busy=%b, required 0000 0", bus.DONE, bus.BUSY);
        end
        $display("test_early_drop done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst_n    = 1'b0;
        bus.REQ  = 4'b0000;
        bus.CODE = 16'h0000;
        test_reset();
        test_round_robin();
        test_single();
        test_code_zero_latch();
        test_reset_mid();
        test_early_drop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
